ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// Streams a burst of words out of a single-port RAM onto a valid/ready output.
// Optional o_last output is enabled by defining RAM_STREAM_READER_LAST_EN.
module ram_stream_reader #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [RAM_ADDR_WIDTH:0]   i_req_len,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [RAM_DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [RAM_DATA_WIDTH-1:0] o_data,
  output logic                      o_busy,
`ifdef RAM_STREAM_READER_LAST_EN
  output logic                      o_last,
`endif
  output logic                      o_done
);

  localparam int LEN_W = RAM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      accept;
  logic                      load;
  logic                      xfer;
  logic [RAM_ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_W-1:0]          rem_cnt;

  assign xfer        = o_valid && i_ready;
  assign o_ram_addr  = addr_cnt;
  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and load decision; a load only happens when the output slot is free or draining
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          accept = 1'b1;
          if (i_req_len != LEN_W'(0)) begin
            state_next = READ;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if ((!o_valid || i_ready) && (rem_cnt != LEN_W'(0))) begin
          load = 1'b1;
          if (rem_cnt == LEN_W'(1)) begin
            state_next = DRAIN;
          end else begin
            state_next = READ;
          end
        end else begin
          state_next = READ;
        end
      end
      DRAIN: begin
        if (!o_valid || i_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address/length counters, output word register and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= {RAM_ADDR_WIDTH{1'b0}};
      rem_cnt  <= {LEN_W{1'b0}};
      o_data   <= {RAM_DATA_WIDTH{1'b0}};
      o_valid  <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= (state == DRAIN) && (state_next == IDLE);
      if (accept) begin
        addr_cnt <= i_req_addr;
        rem_cnt  <= i_req_len;
      end else if (load) begin
        addr_cnt <= addr_cnt + RAM_ADDR_WIDTH'(1);
        rem_cnt  <= rem_cnt - LEN_W'(1);
      end else begin
        addr_cnt <= addr_cnt;
        rem_cnt  <= rem_cnt;
      end
      if (load) begin
        o_data  <= i_ram_rd_data;
        o_valid <= 1'b1;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
    end
  end

`ifdef RAM_STREAM_READER_LAST_EN
  // Tag the word loaded while one word remains; held with o_data under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_last <= 1'b0;
    end else if (load) begin
      o_last <= (rem_cnt == LEN_W'(1));
    end else if (xfer) begin
      o_last <= 1'b0;
    end else begin
      o_last <= o_last;
    end
  end
`endif

endmodule
